// File: rtl/oam_dma_writer.sv
// OAM write port: lands DMA bytes in OAM and shares the single port
// between the DMA engine, the CPU and the PPU sprite scanner.
module oam_dma_writer #(
    parameter int OAM_SIZE = 160,
    parameter int AW       = 8
) (
    input  logic          clk1,
    input  logic          nreset6,
    input  logic          dma_run,
    input  logic [7:0]    dma_idx,
    input  logic [7:0]    dma_data,
    input  logic          dma_valid,
    input  logic          cpu_sel,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          ppu_busy,
    input  logic [7:0]    oam_rdata,
    output logic [AW-1:0] oam_addr,
    output logic [7:0]    oam_wdata,
    output logic          oam_we,
    output logic          oam_re,
    output logic [7:0]    cpu_rdata,
    output logic          dma_busy,
    output logic          dma_done,
    output logic [7:0]    dma_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        XFER,
        DONE
    } state_t;

    localparam logic [7:0]    SIZE8 = 8'(OAM_SIZE);
    localparam logic [AW-1:0] LIMIT = AW'(OAM_SIZE);

    state_t state;
    logic   run_q;
    logic   rd_pend;

    logic run_rise;
    logic dma_act;
    logic dma_acc;
    logic dma_ok;
    logic cpu_lock;
    logic cpu_in;
    logic cpu_rd_s;
    logic cpu_wr_s;

    assign run_rise = dma_run & ~run_q;
    assign dma_act  = (state == ARMED) || (state == XFER);
    assign dma_acc  = dma_act & dma_valid & dma_run;
    assign dma_ok   = dma_acc & (dma_idx < SIZE8);
    assign cpu_lock = dma_act | ppu_busy;
    assign cpu_in   = cpu_addr < LIMIT;
    assign cpu_rd_s = cpu_sel & cpu_rd;
    assign cpu_wr_s = cpu_sel & cpu_wr;

    assign dma_busy = dma_act;
    assign dma_done = (state == DONE);

    always_ff @(posedge clk1) begin
        if (!nreset6) begin
            state     <= IDLE;
            run_q     <= 1'b0;
            rd_pend   <= 1'b0;
            oam_addr  <= '0;
            oam_wdata <= 8'h00;
            oam_we    <= 1'b0;
            oam_re    <= 1'b0;
            cpu_rdata <= 8'hFF;
            dma_count <= 8'h00;
        end else begin
            run_q   <= dma_run;
            oam_we  <= 1'b0;
            oam_re  <= 1'b0;
            rd_pend <= oam_re;

            if (run_rise) begin
                state     <= ARMED;
                dma_count <= 8'h00;
            end else begin
                unique case (state)
                    IDLE: state <= IDLE;
                    ARMED, XFER: begin
                        if (!dma_run) begin
                            state <= IDLE;
                        end else if (dma_valid) begin
                            if (dma_ok && dma_count == SIZE8 - 8'd1)
                                state <= DONE;
                            else
                                state <= XFER;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
                if (dma_ok && dma_count < SIZE8)
                    dma_count <= dma_count + 8'd1;
            end

            // DMA owns the port outright; CPU is locked out whenever busy
            if (dma_ok) begin
                oam_we    <= 1'b1;
                oam_addr  <= AW'(dma_idx);
                oam_wdata <= dma_data;
            end

            if (rd_pend)
                cpu_rdata <= oam_rdata;

            if (cpu_rd_s) begin
                if (cpu_lock || cpu_wr)
                    cpu_rdata <= 8'hFF;
                else if (!cpu_in)
                    cpu_rdata <= 8'h00;
                else begin
                    oam_re   <= 1'b1;
                    oam_addr <= cpu_addr;
                end
            end

            if (cpu_wr_s && !cpu_lock && cpu_in) begin
                oam_we    <= 1'b1;
                oam_addr  <= cpu_addr;
                oam_wdata <= cpu_wdata;
            end
        end
    end

endmodule

// File: doc/oam_dma_writer.md
Name: oam_dma_writer

Overview:
- Consumes the OAM DMA engine's output: the DMA run flag, the low DMA address byte, and the fetched source data byte.
- Writes each byte into OAM and arbitrates the single OAM port between DMA, the CPU and the PPU sprite scanner.
- Sits between the DMA engine and the OAM RAM model. Counts transferred bytes and signals completion.

Parameters:
- OAM_SIZE, 160, number of valid OAM bytes; indices >= OAM_SIZE are never written.
- AW, 8, OAM address width.

Ports:
- clk1  input  1  system clock; all state changes on rising edge.
- nreset6  input  1  synchronous active-low reset, sampled on rising clk1.
- dma_run  input  1  DMA engine transfer active.
- dma_idx  input  8  low byte of DMA address, used as OAM destination index.
- dma_data  input  8  source byte fetched for dma_idx.
- dma_valid  input  1  one-cycle strobe: dma_data/dma_idx are valid this cycle.
- cpu_sel  input  1  CPU addresses FE00-FE9F.
- cpu_rd  input  1  CPU read strobe.
- cpu_wr  input  1  CPU write strobe.
- cpu_addr  input  AW  CPU OAM offset.
- cpu_wdata  input  8  CPU write data.
- ppu_busy  input  1  PPU is scanning/reading OAM (modes 2/3).
- oam_rdata  input  8  OAM read data, valid one cycle after oam_re.
- oam_addr  output  AW  OAM port address.
- oam_wdata  output  8  OAM write data.
- oam_we  output  1  OAM write enable.
- oam_re  output  1  OAM read enable, CPU reads only.
- cpu_rdata  output  8  CPU read result.
- dma_busy  output  1  high while state is ARMED or XFER.
- dma_done  output  1  one-cycle pulse when OAM_SIZE bytes have been written.
- dma_count  output  8  bytes written in the current transfer.

Behaviour:
- Reset (nreset6 low at a rising edge):
  - State = IDLE.
  - oam_addr = 0, oam_wdata = 0, oam_we = 0, oam_re = 0.
  - cpu_rdata = 8'hFF, dma_busy = 0, dma_done = 0, dma_count = 0.
  - The write-pipeline register is cleared. Reset mid-transfer abandons the transfer with no further OAM write.
- State machine:
  - IDLE -> ARMED on dma_run rising edge, detected against a registered copy of dma_run.
  - ARMED -> XFER on the first dma_valid.
  - XFER -> DONE when the write making dma_count = OAM_SIZE is issued.
  - DONE -> IDLE the next cycle; dma_done is high during DONE only.
  - ARMED or XFER -> IDLE if dma_run falls: abort, no dma_done, count is held.
  - dma_run rising while in XFER or DONE (restart) -> ARMED with dma_count cleared to 0.
- DMA write pipeline, 1-cycle latency:
  - A dma_valid in ARMED or XFER captures {dma_idx, dma_data}.
  - Next cycle: oam_we = 1, oam_addr = captured idx, oam_wdata = captured data, dma_count += 1.
  - If the captured idx >= OAM_SIZE, the write is suppressed (oam_we = 0) and dma_count is unchanged.
  - dma_count saturates at OAM_SIZE. It is cleared on entry to ARMED.
- Arbitration per cycle, highest priority first:
  1. Pending DMA write.
  2. dma_busy: CPU locked out.
  3. ppu_busy: CPU locked out.
  4. CPU access.
- When the CPU is locked out:
  - Writes are dropped.
  - Reads return cpu_rdata = 8'hFF one cycle after cpu_rd, with oam_re = 0.
- CPU access (cpu_sel and no lockout):
  - cpu_wr: oam_we = 1, oam_addr = cpu_addr, oam_wdata = cpu_wdata, same cycle (combinational grant, registered outputs).
  - cpu_rd: oam_re = 1. cpu_rdata = oam_rdata one cycle later.
  - cpu_addr >= OAM_SIZE: reads return 8'h00, writes are dropped.
  - cpu_rd and cpu_wr together: the write wins; cpu_rdata returns 8'hFF.
- Output timing:
  - oam_we and oam_re are single-cycle pulses.
  - oam_addr and oam_wdata hold their last values when no access occurs.
  - cpu_rdata holds until the next read completes.
- dma_valid in IDLE or DONE is ignored.

Test Plan:
1. Full transfer: pulse dma_run, then 160 dma_valid strobes with idx 0..159, data = idx XOR 8'h5A -> 160 oam_we pulses each lagging its strobe by one cycle; OAM[0x10] = 8'h4A; dma_count = 160; a single dma_done pulse; then IDLE.
2. CPU lockout: during XFER, cpu_wr to addr 0x20 with 8'h77 and cpu_rd of 0x20 -> no CPU write issued, cpu_rdata = 8'hFF. After done, a read of 0x20 returns the DMA-written value 8'h7A.
3. PPU contention: ppu_busy = 1 with dma idle; cpu_rd of 0x00 -> oam_re stays 0, cpu_rdata = 8'hFF. Drop ppu_busy, reread -> stored byte.
4. Out-of-range: dma_valid with idx 0xA5 -> no oam_we, count unchanged. cpu_rd of 0xA0 -> 8'h00.
5. Abort and restart: drop dma_run after 40 bytes -> IDLE, dma_count = 40, no dma_done. Re-raise dma_run -> ARMED, dma_count = 0.
6. Reset mid-transfer: assert nreset6 low at byte 80 with a write pending -> next edge has oam_we = 0, dma_busy = 0, cpu_rdata = 8'hFF, dma_count = 0.
